// File: rtl/hi_lo_multiply_divide_unit.sv
// HI/LO multiply/divide engine: single-cycle-issue MULT(U), 32-step restoring DIV(U),
// direct MTHI/MTLO writes. busy stalls the front end while an operation is in flight.
module hi_lo_multiply_divide_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_execute,
    input  logic [2:0]            operation_execute,
    input  logic [DATA_WIDTH-1:0] source_A_execute,
    input  logic [DATA_WIDTH-1:0] source_B_execute,
    input  logic                  abort,
    output logic [DATA_WIDTH-1:0] HI_output,
    output logic [DATA_WIDTH-1:0] LO_output,
    output logic                  busy,
    output logic                  done
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam int N  = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, MULTIPLY, DIVIDE, FIXUP} state_t;

    state_t          r_state, w_state_next;
    logic [N-1:0]    r_hi, r_lo;
    logic            r_done;
    logic [N-1:0]    r_a, r_b;
    logic            r_signed;
    logic [N-1:0]    r_rem, r_quot;
    logic [CW-1:0]   r_count;
    logic            r_sign_q, r_sign_r, r_divzero;

    logic            w_accept;
    logic            w_is_mul, w_is_div, w_is_mthi, w_is_mtlo, w_op_signed;
    logic [N-1:0]    w_abs_a, w_abs_b;
    logic [2*N-1:0]  w_a_ext, w_b_ext, w_product;
    logic [N:0]      w_trial;
    logic            w_trial_ok;
    logic [N-1:0]    w_rem_next, w_quot_next;
    logic [N-1:0]    w_q_fix, w_r_fix;

    assign w_accept    = start_execute && (r_state == IDLE) && !abort;
    assign w_is_mul    = (operation_execute[2:1] == 2'b00);
    assign w_is_div    = (operation_execute[2:1] == 2'b01);
    assign w_is_mthi   = (operation_execute == 3'b100);
    assign w_is_mtlo   = (operation_execute == 3'b101);
    assign w_op_signed = ~operation_execute[0];

    // Magnitudes wrap modulo 2^N, which is what makes -2^(N-1)/-1 come out as 0x80..0 / 0.
    assign w_abs_a = (w_op_signed && source_A_execute[N-1]) ? ({N{1'b0}} - source_A_execute)
                                                             : source_A_execute;
    assign w_abs_b = (w_op_signed && source_B_execute[N-1]) ? ({N{1'b0}} - source_B_execute)
                                                             : source_B_execute;

    // Low 2N bits of the sign-extended product equal the signed product.
    assign w_a_ext   = r_signed ? {{N{r_a[N-1]}}, r_a} : {{N{1'b0}}, r_a};
    assign w_b_ext   = r_signed ? {{N{r_b[N-1]}}, r_b} : {{N{1'b0}}, r_b};
    assign w_product = w_a_ext * w_b_ext;

    // One restoring step: remainder is N+1 bits wide so a divisor near 2^N never overflows.
    assign w_trial     = {r_rem, r_quot[N-1]} - {1'b0, r_b};
    assign w_trial_ok  = ~w_trial[N];
    assign w_rem_next  = w_trial_ok ? w_trial[N-1:0] : {r_rem[N-2:0], r_quot[N-1]};
    assign w_quot_next = {r_quot[N-2:0], w_trial_ok};

    assign w_q_fix = r_sign_q ? ({N{1'b0}} - r_quot) : r_quot;
    assign w_r_fix = r_sign_r ? ({N{1'b0}} - r_rem)  : r_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_next = MULTIPLY;
                end else if (w_accept && w_is_div) begin
                    w_state_next = DIVIDE;
                end
            end
            MULTIPLY: w_state_next = IDLE;
            DIVIDE:   w_state_next = (r_count == '0) ? FIXUP : DIVIDE;
            FIXUP:    w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
        if (abort) begin
            w_state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
            r_a       <= '0;
            r_b       <= '0;
            r_signed  <= 1'b0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_count   <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                if (w_is_mthi) begin
                    r_hi   <= source_A_execute;
                    r_done <= 1'b1;
                end else if (w_is_mtlo) begin
                    r_lo   <= source_A_execute;
                    r_done <= 1'b1;
                end else if (w_is_mul) begin
                    r_a      <= source_A_execute;
                    r_b      <= source_B_execute;
                    r_signed <= w_op_signed;
                end else if (w_is_div) begin
                    r_a       <= source_A_execute;
                    r_quot    <= w_abs_a;
                    r_b       <= w_abs_b;
                    r_rem     <= '0;
                    r_count   <= CW'(DATA_WIDTH - 1);
                    r_sign_q  <= w_op_signed & (source_A_execute[N-1] ^ source_B_execute[N-1]);
                    r_sign_r  <= w_op_signed & source_A_execute[N-1];
                    r_divzero <= (source_B_execute == '0);
                end
            end
            if (!abort) begin
                case (r_state)
                    MULTIPLY: begin
                        r_hi   <= w_product[2*N-1:N];
                        r_lo   <= w_product[N-1:0];
                        r_done <= 1'b1;
                    end
                    DIVIDE: begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        if (r_count != '0) begin
                            r_count <= r_count - 1'b1;
                        end
                    end
                    FIXUP: begin
                        r_hi   <= r_divzero ? r_a : w_r_fix;
                        r_lo   <= r_divzero ? {N{1'b1}} : w_q_fix;
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign HI_output = r_hi;
    assign LO_output = r_lo;
    assign busy      = (r_state != IDLE);
    assign done      = r_done;

endmodule
